// File: rtl/ifetch_stage.sv
// ifetch_stage: instruction-fetch stage between the PC block and decode.
//
// Takes one PC at a time over pc_valid/pc_ready. It reads the instruction
// word through a req/gnt/rvalid memory port whose latency varies. The word,
// its PC and PC+4 go to decode through an IF/ID register that can stall and
// flush.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   pc_in/pc_valid/pc_ready       PC handshake from the PC block
//   imem_req/imem_addr/imem_gnt   memory request channel
//   imem_rvalid/imem_rdata        memory response channel
//   id_valid/id_ready             IF/ID handshake; id_ready=0 stalls
//   id_instr/id_pc/id_pc4         IF/ID register contents
//   id_misalign                   id_pc not word aligned (id_instr is a NOP)
//   instr_imm16                   id_instr[15:0], branch-offset source
//   flush                         kill the in-flight or held fetch
//   fetch_cnt/stall_cnt           saturating performance counters
//
// state | meaning
// IDLE  | nothing in flight, waiting for a PC
// REQ   | imem_req high for pc_q, waiting for grant
// WAIT  | granted, waiting for read data
// OUT   | IF/ID register valid, waiting for decode
// DROP  | flushed after grant, swallowing the orphan response
module ifetch_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc4,
  output logic              id_misalign,
  output logic [15:0]       instr_imm16,
  input  logic              flush,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, DROP} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              imem_req_q;
  logic              id_valid_q;
  logic [DATA_W-1:0] id_instr_q;
  logic [ADDR_W-1:0] id_pc_q;
  logic [ADDR_W-1:0] id_pc4_q;
  logic              id_misalign_q;
  logic [CNT_W-1:0]  fetch_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic accept;
  logic pc_in_mis;

  // A flush cycle never takes a new PC, even from IDLE.
  assign pc_ready  = !flush && ((state_q == IDLE) || ((state_q == OUT) && id_ready));
  assign accept    = pc_valid && pc_ready;
  assign pc_in_mis = (pc_in[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      imem_req_q    <= 1'b0;
      id_valid_q    <= 1'b0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      id_pc4_q      <= '0;
      id_misalign_q <= 1'b0;
      fetch_cnt_q   <= '0;
      stall_cnt_q   <= '0;
    end else begin
      if (id_valid_q && !id_ready && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);

      unique case (state_q)
        IDLE: ;  // stray responses here belong to a fetch killed by reset
        REQ: begin
          if (flush) begin
            imem_req_q <= 1'b0;
            // a grant in the flush cycle still yields a response to swallow
            state_q    <= imem_gnt ? DROP : IDLE;
          end else if (imem_gnt) begin
            imem_req_q <= 1'b0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            state_q <= imem_rvalid ? IDLE : DROP;
          end else if (imem_rvalid) begin
            id_instr_q    <= imem_rdata;
            id_pc_q       <= pc_q;
            id_pc4_q      <= pc_q + ADDR_W'(4);
            id_misalign_q <= 1'b0;
            id_valid_q    <= 1'b1;
            if (fetch_cnt_q != '1)
              fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
            state_q       <= OUT;
          end
        end
        OUT: begin
          if (flush || id_ready) begin
            id_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        DROP: begin
          if (imem_rvalid)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // A new PC overrides the IDLE/OUT decisions above; accept already
      // excludes flush and every state other than IDLE and OUT.
      if (accept) begin
        pc_q <= pc_in;
        if (pc_in_mis) begin
          id_instr_q    <= '0;
          id_pc_q       <= pc_in;
          id_pc4_q      <= pc_in + ADDR_W'(4);
          id_misalign_q <= 1'b1;
          id_valid_q    <= 1'b1;
          imem_req_q    <= 1'b0;
          state_q       <= OUT;
        end else begin
          id_valid_q    <= 1'b0;
          imem_req_q    <= 1'b1;
          state_q       <= REQ;
        end
      end
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc4      = id_pc4_q;
  assign id_misalign = id_misalign_q;
  assign instr_imm16 = id_instr_q[15:0];
  assign fetch_cnt   = fetch_cnt_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Instruction-fetch stage directly downstream of the program-counter block.
- Accepts each PC value over a valid/ready handshake and fetches the 32-bit word from instruction memory, which has a request/grant/response interface with variable latency.
- Presents the instruction, its PC and PC+4 to decode through an IF/ID register that supports stall and flush.
- Returns instruction bits [15:0] to the PC block as the branch-offset source.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address
- DATA_W, 32, instruction width
- CNT_W, 16, width of the saturating performance counters

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- pc_in  input  ADDR_W  PC from the PC block
- pc_valid  input  1  pc_in is valid
- pc_ready  output  1  stage accepts pc_in this cycle
- imem_req  output  1  memory read request
- imem_addr  output  ADDR_W  memory read address
- imem_gnt  input  1  request accepted
- imem_rvalid  input  1  read data valid
- imem_rdata  input  DATA_W  read data
- id_valid  output  1  IF/ID register holds a valid instruction
- id_ready  input  1  decode consumes the instruction; low means stall
- id_instr  output  DATA_W  fetched instruction
- id_pc  output  ADDR_W  PC of id_instr
- id_pc4  output  ADDR_W  id_pc + 4, modulo 2^ADDR_W
- id_misalign  output  1  id_pc[1:0] != 0
- instr_imm16  output  16  id_instr[15:0], sent to the PC block
- flush  input  1  kill the in-flight or held fetch (taken branch)
- fetch_cnt  output  CNT_W  completed fetches, saturating
- stall_cnt  output  CNT_W  cycles with id_valid=1 and id_ready=0, saturating

Behaviour:
- Reset (asynchronous, to this state):
  - state=IDLE
  - id_valid=0, imem_req=0, id_misalign=0
  - id_instr, id_pc, id_pc4 = 0
  - fetch_cnt=0, stall_cnt=0
  - pc_ready=1
- Reset asserted mid-fetch: the outstanding response is not tracked; the first imem_rvalid seen in IDLE is ignored.
- States: IDLE, REQ, WAIT, OUT, DROP.
- IDLE:
  - pc_ready=1.
  - On pc_valid, latch pc_in into pc_q.
  - If pc_in[1:0] != 0: go to OUT with id_instr=0 (NOP), id_misalign=1, and no memory access.
  - Otherwise go to REQ.
- REQ:
  - imem_req=1, imem_addr=pc_q, both stable until imem_gnt.
  - imem_gnt → WAIT. A response in the same cycle as the grant is not permitted.
- WAIT:
  - imem_req=0.
  - imem_rvalid → capture id_instr=imem_rdata, id_pc=pc_q, id_pc4=pc_q+4, id_misalign=0; increment fetch_cnt; go to OUT.
  - Minimum latency PC-accept to id_valid is 3 cycles (accept, grant, rvalid).
- OUT:
  - id_valid=1.
  - id_ready=0: all outputs hold; stall_cnt increments.
  - id_ready=1 with pc_valid: pc_ready=1, accept the new PC back-to-back and go to REQ (or OUT directly if misaligned).
  - id_ready=1 without pc_valid: go to IDLE.
  - pc_ready=0 in OUT unless id_ready=1.
- Flush has priority over every other event in the same cycle and never accepts pc_in in its own cycle:
  - IDLE: no effect.
  - REQ: drop imem_req next cycle, go to IDLE; a grant in the same cycle is treated as WAIT-then-flush, so go to DROP.
  - WAIT: go to DROP; if imem_rvalid arrives in the same cycle, discard it and go to IDLE.
  - OUT: id_valid=0 next cycle, go to IDLE.
- DROP: imem_req=0, pc_ready=0; discard the next imem_rvalid, then go to IDLE.
- Counters saturate at all-ones with no wrap.
- id_pc4 wraps: 0xFFFFFFFC+4 = 0x00000000.
- instr_imm16 is combinational from id_instr.

Test Plan:
- Reset, then pc_in=0x00000040; gnt 1 cycle later; rvalid 2 cycles later with rdata=0x1234ABCD → id_valid with id_pc=0x40, id_pc4=0x44, instr_imm16=0xABCD, fetch_cnt=1.
- id_ready held 0 for 5 cycles in OUT → outputs frozen, stall_cnt=5; id_ready=1 with pc_valid, pc_in=0x44 → imem_req for 0x44 on the next cycle.
- flush in WAIT, then rvalid with rdata=0xDEADBEEF → id_valid stays 0, fetch_cnt unchanged, returns to IDLE with pc_ready=1.
- pc_in=0x00000042 → no imem_req; id_valid=1, id_misalign=1, id_instr=0.
- pc_in=0xFFFFFFFC, rdata=0x00000010 → id_pc4=0x00000000.
- rst asserted during REQ → imem_req=0 and id_valid=0 immediately (asynchronous); a stray rvalid afterwards is ignored.
